vend_controller: RTL

Transaction sequencer for the beverage dispenser datapath. Accumulates coin credit, issues a single-cycle selection request with the credit value to the dispenser, and waits for the dispense pulse and change amount. It then pays change out one coin per cycle. It also handles cancel/refund, over-credit rejection, and selections the dispenser refuses for insufficient funds.

---
 rtl/vend_controller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vend_controller.sv
// Beverage vending transaction sequencer: collects coins, requests a dispense,
// waits for confirmation or timeout, then pays change out one coin per cycle.
module vend_controller #(
    parameter int MAX_CREDIT = 1000,
    parameter int TIMEOUT    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic [3:0] sel,
    input  logic       cancel,
    input  logic [3:0] bev_done,
    input  logic [9:0] change_in,
    output logic [3:0] bev_req,
    output logic [9:0] credit,
    output logic       coin_reject,
    output logic       vend_ok,
    output logic       denied,
    output logic       pay_valid,
    output logic [1:0] pay_coin,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, COLLECT, REQ, WAIT, PAYOUT} state_t;

    state_t     state, state_nxt;
    logic [9:0] remain, remain_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [10:0] coin_value, credit_sum;
    logic [9:0] pay_amt;
    logic [1:0] pay_code;
    logic [3:0] sel_onehot;
    logic       coin_fits, do_cancel, sel_take, accept, done_any, timeout;

    logic [3:0] bev_req_nxt;
    logic [9:0] credit_nxt;
    logic [1:0] pay_coin_nxt;
    logic       reject_nxt, vend_ok_nxt, denied_nxt, pay_valid_nxt, busy_nxt;

    always_comb begin
        case (coin_code)
            2'b00:   coin_value = 11'd5;
            2'b01:   coin_value = 11'd10;
            2'b10:   coin_value = 11'd25;
            default: coin_value = 11'd100;
        endcase
    end

    always_comb begin
        if (remain >= 10'd25) begin
            pay_amt  = 10'd25;
            pay_code = 2'b10;
        end else if (remain >= 10'd10) begin
            pay_amt  = 10'd10;
            pay_code = 2'b01;
        end else begin
            pay_amt  = 10'd5;
            pay_code = 2'b00;
        end
    end

    assign credit_sum = {1'b0, credit} + coin_value;
    assign coin_fits  = credit_sum <= 11'(MAX_CREDIT);
    assign sel_onehot = sel & (~sel + 4'd1);
    assign do_cancel  = (state == COLLECT) && cancel && (credit != 10'd0);
    assign sel_take   = (state == COLLECT) && !cancel && (sel != 4'd0) && (credit != 10'd0);
    assign accept     = coin_valid && (state == IDLE || state == COLLECT)
                        && !do_cancel && !sel_take && coin_fits;
    assign done_any   = bev_done != 4'd0;
    // cnt counts cycles since the request was presented (REQ cycle = 0), so the
    // denied pulse lands TIMEOUT cycles after bev_req.
    assign timeout    = cnt == 4'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remain      <= '0;
            cnt         <= '0;
            credit      <= '0;
            bev_req     <= '0;
            coin_reject <= 1'b0;
            vend_ok     <= 1'b0;
            denied      <= 1'b0;
            pay_valid   <= 1'b0;
            pay_coin    <= 2'b00;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            remain      <= remain_nxt;
            cnt         <= cnt_nxt;
            credit      <= credit_nxt;
            bev_req     <= bev_req_nxt;
            coin_reject <= reject_nxt;
            vend_ok     <= vend_ok_nxt;
            denied      <= denied_nxt;
            pay_valid   <= pay_valid_nxt;
            pay_coin    <= pay_coin_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = COLLECT;
            COLLECT: begin
                if (do_cancel)     state_nxt = PAYOUT;
                else if (sel_take) state_nxt = REQ;
            end
            REQ:     state_nxt = WAIT;
            WAIT: begin
                if (done_any)     state_nxt = (change_in != 10'd0) ? PAYOUT : IDLE;
                else if (timeout) state_nxt = COLLECT;
            end
            PAYOUT:  if (remain < 10'd5 || remain == pay_amt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        remain_nxt    = remain;
        cnt_nxt       = cnt;
        credit_nxt    = credit;
        bev_req_nxt   = 4'd0;
        reject_nxt    = coin_valid && !accept;
        vend_ok_nxt   = 1'b0;
        denied_nxt    = 1'b0;
        pay_valid_nxt = 1'b0;
        pay_coin_nxt  = 2'b00;
        case (state)
            IDLE, COLLECT: begin
                if (accept) credit_nxt = credit_sum[9:0];
                if (do_cancel) begin
                    remain_nxt = credit;
                    credit_nxt = 10'd0;
                end
                if (sel_take) begin
                    bev_req_nxt = sel_onehot;
                    cnt_nxt     = 4'd0;
                end
            end
            REQ:  cnt_nxt = cnt + 4'd1;
            WAIT: begin
                cnt_nxt = cnt + 4'd1;
                if (done_any) begin
                    remain_nxt  = change_in;
                    credit_nxt  = 10'd0;
                    vend_ok_nxt = 1'b1;
                end else if (timeout) begin
                    denied_nxt = 1'b1;
                end
            end
            PAYOUT: begin
                // a residue under 5c is dropped without paying a coin
                if (remain >= 10'd5) begin
                    pay_valid_nxt = 1'b1;
                    pay_coin_nxt  = pay_code;
                    remain_nxt    = remain - pay_amt;
                end
            end
            default: ;
        endcase
        busy_nxt = (state_nxt == REQ) || (state_nxt == WAIT) || (state_nxt == PAYOUT);
    end

endmodule
